// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST controller: FSM states,
// LFSR tap mask, default seeds and the four fixed corner vectors.
package adder_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7,5,4,3 feed bit 0
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] DEF_SEED_A = 8'hA5;
  localparam logic [7:0] DEF_SEED_B = 8'h3C;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
  } vec_t;

  function automatic vec_t corner_vec(input logic [1:0] idx);
    case (idx)
      2'd0:    return vec_t'{a: 8'hFF, b: 8'h01, sub: 1'b0, cin: 1'b0};
      2'd1:    return vec_t'{a: 8'hAA, b: 8'h55, sub: 1'b0, cin: 1'b0};
      2'd2:    return vec_t'{a: 8'h00, b: 8'h01, sub: 1'b1, cin: 1'b0};
      default: return vec_t'{a: 8'h80, b: 8'h80, sub: 1'b1, cin: 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shifts left with feedback into bit 0.
// A zero seed is replaced by 8'h01 so the register never locks up.
module lfsr8
  import adder_bist_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] seed_eff;
  logic [7:0] q_q;

  assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;
  assign q        = q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q_q <= seed_eff;
    else if (load) q_q <= seed_eff;
    else if (step) q_q <= {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

endmodule

// File: rtl/adder_bist.sv
// BIST controller for the 8-bit add/subtract unit: drives corner then LFSR
// vectors, checks {c7,sum} against a computed result, reports pass/fail.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  SEED_A        = DEF_SEED_A,
  parameter logic [7:0]  SEED_B        = DEF_SEED_B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       cin0,
  output logic       subtract,
  input  logic       c7,
  input  logic [7:0] sum,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] fail_a,
  output logic [7:0] fail_b,
  output logic       fail_sub
);

  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [15:0] idx_q;
  logic [3:0]  settle_q;
  vec_t        vec_q, vec_d;
  logic        busy_q, done_q, pass_q;
  logic [7:0]  err_q, err_d;
  logic [7:0]  fail_a_q, fail_b_q;
  logic        fail_sub_q;
  logic [7:0]  lfsr_a, lfsr_b;
  logic        start_ok, lfsr_step, mismatch, last;

  // Subtraction is a + ~b + 1; carry out set means no borrow.
  function automatic logic [8:0] expected(input vec_t v);
    if (v.sub) return {1'b0, v.a} + {1'b0, ~v.b} + 9'd1;
    return {1'b0, v.a} + {1'b0, v.b} + {8'd0, v.cin};
  endfunction

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last      = (idx_q == LAST_IDX);
  assign lfsr_step = (state_q == S_CHECK) && (idx_q >= 16'd3);
  assign mismatch  = ({c7, sum} != expected(vec_q));
  assign err_d     = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

  lfsr8 u_lfsr_a (
    .clk(clk), .reset(reset), .load(start_ok), .seed(SEED_A), .step(lfsr_step), .q(lfsr_a)
  );
  lfsr8 u_lfsr_b (
    .clk(clk), .reset(reset), .load(start_ok), .seed(SEED_B), .step(lfsr_step), .q(lfsr_b)
  );

  always_comb begin
    vec_d = '0;
    if (idx_q < 16'd4) begin
      vec_d = corner_vec(idx_q[1:0]);
    end else begin
      vec_d.a   = lfsr_a;
      vec_d.b   = lfsr_b;
      vec_d.sub = idx_q[0];
      vec_d.cin = idx_q[1] & ~idx_q[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_sub_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_DRIVE;
            idx_q      <= '0;
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_sub_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        S_DRIVE: begin
          vec_q    <= vec_d;
          settle_q <= SETTLE_LAST;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == 4'd0) state_q  <= S_CHECK;
          else                  settle_q <= settle_q - 4'd1;
        end
        S_CHECK: begin
          err_q <= err_d;
          // err_q only grows on a mismatch, so zero marks the first one
          if (mismatch && err_q == 8'd0) begin
            fail_a_q   <= vec_q.a;
            fail_b_q   <= vec_q.b;
            fail_sub_q <= vec_q.sub;
          end
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
          end else begin
            idx_q   <= idx_q + 16'd1;
            state_q <= S_DRIVE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a         = vec_q.a;
  assign b         = vec_q.b;
  assign cin0      = vec_q.cin;
  assign subtract  = vec_q.sub;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_sub  = fail_sub_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two controllers (4 and 300 vectors) each beside a
// behavioural adder with selectable faults; results checked by a scoreboard.
module tb_adder_bist;

  localparam int N0 = 4;
  localparam int N1 = 300;
  localparam int SC = 2;
  localparam int P  = 2 + SC;

  logic       clk = 1'b0;
  logic       reset;
  logic       start [2];
  logic [7:0] a [2], b [2], sum [2], err_count [2], fail_a [2], fail_b [2];
  logic       cin0 [2], subtract [2], c7 [2], busy [2], done [2], pass [2], fail_sub [2];
  int         fault [2];
  int         nchk = 0;
  int         nerr = 0;

  typedef struct { logic [7:0] a, b; logic sub, cin; } vec_t;
  typedef struct { int cyc; logic [7:0] err, fa, fb; logic fs, pass; } res_t;
  vec_t vq [$];
  res_t rq0 [$], rq1 [$];

  always #5 clk = ~clk;

  // Fault modes: 1 sum[0] stuck-0, 2 c7 stuck-0, 3 sum inverted.
  function automatic logic [8:0] adder(input logic [7:0] x, y, input logic ci, s, input int f);
    logic [8:0] r;
    r = s ? {1'b0, x} + {1'b0, ~y} + 9'd1 : {1'b0, x} + {1'b0, y} + {8'd0, ci};
    if (f == 1) r[0] = 1'b0;
    if (f == 2) r[8] = 1'b0;
    if (f == 3) r[7:0] = ~r[7:0];
    return r;
  endfunction

  assign {c7[0], sum[0]} = adder(a[0], b[0], cin0[0], subtract[0], fault[0]);
  assign {c7[1], sum[1]} = adder(a[1], b[1], cin0[1], subtract[1], fault[1]);

  adder_bist #(.NUM_VECTORS(N0), .SETTLE_CYCLES(SC)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .a(a[0]), .b(b[0]), .cin0(cin0[0]),
    .subtract(subtract[0]), .c7(c7[0]), .sum(sum[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_count[0]), .fail_a(fail_a[0]), .fail_b(fail_b[0]),
    .fail_sub(fail_sub[0])
  );

  adder_bist #(.NUM_VECTORS(N1), .SETTLE_CYCLES(SC), .SEED_B(8'h00)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .a(a[1]), .b(b[1]), .cin0(cin0[1]),
    .subtract(subtract[1]), .c7(c7[1]), .sum(sum[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_count[1]), .fail_a(fail_a[1]), .fail_b(fail_b[1]),
    .fail_sub(fail_sub[1])
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] lstep(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Reference run: builds the vector list and the final report from the rules.
  task automatic model(input int d, input int n, input int f);
    logic [7:0] sa, sb;
    int errs, ex, got;
    vec_t v;
    res_t r;
    sa = 8'hA5;
    sb = (d == 0) ? 8'h3C : 8'h01;
    errs = 0;
    r = '{cyc: n * P, err: 0, fa: 0, fb: 0, fs: 0, pass: 0};
    for (int k = 0; k < n; k++) begin
      case (k)
        0: v = '{8'hFF, 8'h01, 1'b0, 1'b0};
        1: v = '{8'hAA, 8'h55, 1'b0, 1'b0};
        2: v = '{8'h00, 8'h01, 1'b1, 1'b0};
        3: v = '{8'h80, 8'h80, 1'b1, 1'b0};
        default: v = '{sa, sb, (k % 2) == 1, (k % 4) == 2};
      endcase
      ex = v.sub ? int'(v.a) + (255 - int'(v.b)) + 1 : int'(v.a) + int'(v.b) + int'(v.cin);
      got = ex;
      if (f == 1) got = got & ~1;
      if (f == 2) got = got & 255;
      if (f == 3) got = got ^ 255;
      if (got != ex) begin
        if (errs == 0) begin r.fa = v.a; r.fb = v.b; r.fs = v.sub; end
        errs++;
      end
      if (k >= 3) begin sa = lstep(sa); sb = lstep(sb); end
      if (d == 1) vq.push_back(v);
    end
    r.err  = (errs > 255) ? 8'd255 : 8'(errs);
    r.pass = (errs == 0);
    if (d == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic chk_idle(input int d);
    chk($sformatf("idle%0d", d),
        {a[d], b[d], cin0[d], subtract[d], busy[d], done[d], pass[d], err_count[d],
         fail_a[d], fail_b[d], fail_sub[d]}, 64'd0);
  endtask

  task automatic run(input int d, input int f, input bit noise, input bit clr);
    int n, t, r;
    n = (d == 0) ? N0 : N1;
    r = $urandom_range(8, n * P - 8);
    fault[d] = f;
    model(d, n, f);
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    if (clr)
      chk("restart_clear", {busy[d], done[d], err_count[d], fail_a[d], fail_b[d], fail_sub[d]},
          {1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0});
    t = 0;
    while (done[d] !== 1'b1 && t < n * P + 20) begin
      @(negedge clk);
      t++;
      start[d] = noise && (t == r || t == r + 3);
    end
    start[d] = 1'b0;
    chk("done_seen", done[d], 1'b1);
    repeat ($urandom_range(1, 5)) @(negedge clk);
  endtask

  // Scoreboard monitor: per-vector operands (dut1) and end-of-run reports.
  initial begin : mon
    logic busy_p [2], done_p [2];
    int   cyc [2];
    vec_t v;
    res_t r;
    busy_p = '{1'b0, 1'b0};
    done_p = '{1'b0, 1'b0};
    cyc    = '{0, 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        vq.delete(); rq0.delete(); rq1.delete();
        busy_p = '{1'b0, 1'b0};
        done_p = '{1'b0, 1'b0};
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (busy[d] && !busy_p[d]) cyc[d] = 0; else cyc[d]++;
          if (d == 1 && busy[1] && cyc[1] >= 2 && (cyc[1] - 2) % P == 0) begin
            if (vq.size() == 0) chk("vec_queue", 0, 1);
            else begin
              v = vq.pop_front();
              chk("vec_a", a[1], v.a);
              chk("vec_b", b[1], v.b);
              chk("vec_sub", subtract[1], v.sub);
              chk("vec_cin", cin0[1], v.cin);
            end
          end
          if (done[d] && !done_p[d]) begin
            if ((d == 0 ? rq0.size() : rq1.size()) == 0) chk("res_queue", 0, 1);
            else begin
              r = (d == 0) ? rq0.pop_front() : rq1.pop_front();
              chk($sformatf("run_len%0d", d), cyc[d], r.cyc);
              chk($sformatf("err_count%0d", d), err_count[d], r.err);
              chk($sformatf("pass%0d", d), pass[d], r.pass);
              chk($sformatf("fail_a%0d", d), fail_a[d], r.fa);
              chk($sformatf("fail_b%0d", d), fail_b[d], r.fb);
              chk($sformatf("fail_sub%0d", d), fail_sub[d], r.fs);
              chk($sformatf("busy_low%0d", d), busy[d], 1'b0);
            end
          end
          busy_p[d] = busy[d];
          done_p[d] = done[d];
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    fault = '{0, 0};
    repeat (3) @(negedge clk);
    chk_idle(0);
    chk_idle(1);
    reset = 1'b0;

    run(0, 0, 1'b0, 1'b0);   // golden: pass, 16-cycle run
    run(0, 1, 1'b0, 1'b1);   // sum[0] stuck-0: err 2, first AA/55
    run(0, 2, 1'b0, 1'b1);   // c7 stuck-0: first failure FF/01

    run(1, 0, 1'b1, 1'b0);   // golden with ignored start pulses mid-run
    run(1, 3, 1'b1, 1'b0);   // inverted sum: saturates at 255
    run(1, 0, 1'b0, 1'b1);   // restart from DONE clears the report

    // Abort mid-run; everything must clear at once.
    fault[1] = 0;
    model(1, N1, 0);
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk_idle(1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("flushed", vq.size() + rq1.size(), 0);

    run(1, 0, 1'b0, 1'b0);   // same sequence after abort
    chk("vq_empty", vq.size(), 0);
    chk("rq_empty", rq0.size() + rq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
